// File: rtl/ponylink_seq_checker.sv
// Receive-side sequence checker for incrementing counter words: lock/loss tracking, error count, LED status.
// Latency: 1 cycle from accept to every output; all outputs come straight from flops.
// Backpressure: in_tready is registered, always high or low one cycle in every STALL_PERIOD, independent of in_tvalid.
module ponylink_seq_checker #(
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned ERR_HOLD       = 500000,
    parameter int unsigned STALL_PERIOD   = 0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    input  logic             resync,
    output logic             locked,
    output logic [15:0]      err_count,
    output logic [7:0]       leds
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned EW = (ERR_HOLD > 0) ? $clog2(ERR_HOLD + 1) : 1;
    localparam int unsigned SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [15:0]      errc_q, errc_d;
    logic [EW-1:0]    errt_q, errt_d;
    logic [TW-1:0]    to_q, to_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic             tready_q, tready_d;
    logic [3:0]       hi_q, hi_d;
    logic             tog_q, tog_d;
    logic             accept;

    assign accept = in_tvalid & tready_q;

    generate
        if (STALL_PERIOD == 0) begin : g_nostall
            assign stall_d  = stall_q;
            assign tready_d = 1'b1;
        end else begin : g_stall
            assign stall_d  = (stall_q == SW'(STALL_PERIOD - 1)) ? '0 : stall_q + 1'b1;
            assign tready_d = (stall_d != SW'(STALL_PERIOD - 1));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        errc_d  = errc_q;
        errt_d  = errt_q;
        to_d    = to_q;
        hi_d    = hi_q;
        tog_d   = tog_q;
        if (errt_q != '0) begin
            errt_d = errt_q - 1'b1;
        end
        // resync beats a simultaneous accept: the handshaked word is dropped unseen
        if (resync) begin
            state_d = IDLE;
            to_d    = '0;
        end else if (accept) begin
            state_d = LOCKED;
            to_d    = '0;
            exp_d   = in_tdata + 1'b1;
            hi_d    = in_tdata[WIDTH-1 -: 4];
            tog_d   = ~tog_q;
            if ((state_q == LOCKED) && (in_tdata != exp_q)) begin
                if (errc_q != 16'hFFFF) begin
                    errc_d = errc_q + 16'd1;
                end
                errt_d = EW'(ERR_HOLD);
            end
        end else if (state_q == LOCKED) begin
            if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = LOST;
                to_d    = '0;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            exp_q    <= '0;
            errc_q   <= '0;
            errt_q   <= '0;
            to_q     <= '0;
            stall_q  <= '0;
            tready_q <= 1'b0;
            hi_q     <= '0;
            tog_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            errc_q   <= errc_d;
            errt_q   <= errt_d;
            to_q     <= to_d;
            stall_q  <= stall_d;
            tready_q <= tready_d;
            hi_q     <= hi_d;
            tog_q    <= tog_d;
        end
    end

    assign in_tready = tready_q;
    assign locked    = (state_q == LOCKED);
    assign err_count = errc_q;
    assign leds      = {hi_q, (state_q == LOCKED), (state_q == LOST), (errt_q != '0), tog_q};

endmodule

// File: tb/tb_ponylink_seq_checker.sv
// Directed bench: a free-running instance and a STALL_PERIOD=4 instance, small timeout/hold values.
module tb_ponylink_seq_checker;
    localparam int W  = 16;
    localparam int TO = 8;
    localparam int EH = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [W-1:0]  in_tdata, s_tdata;
    logic          in_tvalid, s_tvalid;
    logic          in_tready, s_tready;
    logic          resync, s_resync;
    logic          locked, s_locked;
    logic [15:0]   err_count, s_err_count;
    logic [7:0]    leds, s_leds;

    int tests = 0;
    int fails = 0;

    ponylink_seq_checker #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .ERR_HOLD(EH), .STALL_PERIOD(0)) dut (
        .clk(clk), .resetn(resetn), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .resync(resync), .locked(locked), .err_count(err_count), .leds(leds)
    );

    ponylink_seq_checker #(.WIDTH(W), .TIMEOUT_CYCLES(TO), .ERR_HOLD(EH), .STALL_PERIOD(4)) dut_s (
        .clk(clk), .resetn(resetn), .in_tdata(s_tdata), .in_tvalid(s_tvalid), .in_tready(s_tready),
        .resync(s_resync), .locked(s_locked), .err_count(s_err_count), .leds(s_leds)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] w);
        in_tdata  = w;
        in_tvalid = 1'b1;
        step();
        in_tvalid = 1'b0;
    endtask

    initial begin
        int pend;
        int acc;
        int hold;
        resetn    = 1'b0;
        in_tdata  = '0;
        in_tvalid = 1'b0;
        resync    = 1'b0;
        s_tdata   = 16'h0040;
        s_tvalid  = 1'b1;
        s_resync  = 1'b0;
        #1;
        check("rst_locked", locked, 0);
        check("rst_leds", leds, 8'h00);
        check("rst_err", err_count, 0);
        check("rst_rdy", in_tready, 0);
        check("rst_s_rdy", s_tready, 0);
        repeat (3) step();
        resetn = 1'b1;

        // stalled instance: valid held, data advances only on handshake
        acc = 0;
        for (int n = 1; n <= 17; n++) begin
            pend = s_tready;
            step();
            if (pend != 0) begin
                acc++;
                s_tdata = s_tdata + 16'd1;
            end
            check($sformatf("s_rdy_%0d", n), s_tready, ((n % 4) != 3));
            if (n == 1) check("rdy_after_rst", in_tready, 1);
        end
        s_tvalid = 1'b0;
        check("s_accepts", acc, 12);
        check("s_err", s_err_count, 0);
        check("s_locked", s_locked, 1);
        check("s_leds_hi_nibble", s_leds[7:4], 4'h0);

        // back-to-back lock
        send(16'h0005);
        check("lock1", locked, 1);
        check("tog1", leds[0], 1);
        send(16'h0006);
        check("tog2", leds[0], 0);
        send(16'h0007);
        check("tog3", leds[0], 1);
        check("err_b2b", err_count, 0);
        check("leds_b2b", leds, 8'h09);

        // wrap-around
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_idle", locked, 0);
        send(16'hFFFE);
        send(16'hFFFF);
        check("hi_ffff", leds[7:4], 4'hF);
        send(16'h0000);
        send(16'h0001);
        check("wrap_err", err_count, 0);
        check("wrap_locked", locked, 1);

        // single glitch costs one error; error LED hold length
        resync = 1'b1;
        step();
        resync = 1'b0;
        send(16'h000F);
        send(16'h0020);
        check("glitch_err", err_count, 1);
        check("errled_on", leds[1], 1);
        hold = 1;
        send(16'h0021);
        check("reanchor_err", err_count, 1);
        if (leds[1]) hold++;
        for (int i = 0; i < 8; i++) begin
            send(16'h0022 + 16'(i));
            if (leds[1]) hold++;
        end
        check("errled_cycles", hold, EH);
        check("no_second_err", err_count, 1);
        check("errled_off", leds[1], 0);

        // timeout to LOST
        repeat (TO - 1) step();
        check("to_still_locked", locked, 1);
        check("to_not_lost", leds[2], 0);
        step();
        check("to_unlocked", locked, 0);
        check("to_lost", leds[2], 1);
        send(16'h1234);
        check("relock", locked, 1);
        check("relock_lost_clr", leds[2], 0);
        check("relock_err", err_count, 1);
        check("relock_hi", leds[7:4], 4'h1);

        // resync wins over simultaneous accept
        in_tdata  = 16'h0100;
        in_tvalid = 1'b1;
        resync    = 1'b1;
        step();
        in_tvalid = 1'b0;
        resync    = 1'b0;
        check("resync_acc_idle", locked, 0);
        check("resync_acc_notlost", leds[2], 0);
        send(16'h0500);
        check("resync_relock", locked, 1);
        check("resync_err_kept", err_count, 1);
        send(16'h0501);
        check("resync_seq_err", err_count, 1);

        // asynchronous reset mid-stream
        in_tdata  = 16'h0502;
        in_tvalid = 1'b1;
        #3;
        resetn = 1'b0;
        #1;
        check("arst_locked", locked, 0);
        check("arst_err", err_count, 0);
        check("arst_leds", leds, 8'h00);
        check("arst_rdy", in_tready, 0);
        in_tvalid = 1'b0;
        step();
        resetn = 1'b1;
        step();
        send(16'h0777);
        check("arst_relock", locked, 1);
        check("arst_relock_err", err_count, 0);
        check("arst_relock_leds", leds, 8'h09);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
